// File: rtl/seg_pkg.sv
// Shared definitions for the segment-display shift controller.
// Holds the controller state encoding, the default frame width and divider,
// and the counter widths used by the controller and its tick generator.
package seg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2,
    ST_DONE  = 2'd3
  } seg_state_e;

  localparam int unsigned SEG_WIDTH_DEF = 64;
  localparam int unsigned SEG_DIV_DEF   = 2;

  // bitcnt must hold WIDTH-1; divcnt must hold DIV-1 for DIV up to 1023.
  localparam int unsigned SEG_BITCNT_W  = 16;
  localparam int unsigned SEG_DIVCNT_W  = 10;

endpackage

// File: rtl/seg_div_tick.sv
// DIV-cycle tick generator.
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   i_en       : count enable (controller is in SHIFT or LATCH)
//   i_clr      : synchronous clear of the divider count
//   o_tick     : high in the last cycle of every DIV-cycle period while enabled
module seg_div_tick
  import seg_pkg::*;
#(
  parameter int unsigned DIV = SEG_DIV_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam logic [SEG_DIVCNT_W-1:0] DIV_LAST = SEG_DIVCNT_W'(DIV - 1);

  logic [SEG_DIVCNT_W-1:0] r_divcnt;

  assign o_tick = i_en && (r_divcnt == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_divcnt <= '0;
    end else if (i_clr) begin
      r_divcnt <= '0;
    end else if (i_en) begin
      if (o_tick) r_divcnt <= '0;
      else        r_divcnt <= r_divcnt + SEG_DIVCNT_W'(1);
    end
  end

endmodule

// File: rtl/seg_shift_ctrl.sv
// Serial shift controller for a segment-display shift-register chain.
// Captures a WIDTH-bit frame on start, shifts it out MSB first with a
// 2*DIV-cycle serial clock, strobes the chain latch for DIV cycles, then
// pulses done for one cycle.
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   start      : frame request, sampled only in IDLE
//   par_data   : frame to send, bit WIDTH-1 first
//   busy       : high in SHIFT and LATCH
//   done       : one-cycle completion pulse
//   seg_clk    : serial clock, chain samples on its rising edge
//   seg_sout   : serial data, changes only on seg_clk falling edges
//   seg_latch  : chain latch strobe
module seg_shift_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned WIDTH = SEG_WIDTH_DEF,
  parameter int unsigned DIV   = SEG_DIV_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] par_data,
  output logic             busy,
  output logic             done,
  output logic             seg_clk,
  output logic             seg_sout,
  output logic             seg_latch
);

  localparam logic [SEG_BITCNT_W-1:0] BIT_LAST = SEG_BITCNT_W'(WIDTH - 1);

  seg_state_e              r_state;
  seg_state_e              w_state_nxt;
  logic [WIDTH-1:0]        r_shift;
  logic [SEG_BITCNT_W-1:0] r_bitcnt;
  logic                    r_segclk;
  logic                    w_tick;
  logic                    w_div_en;
  logic                    w_div_clr;
  logic                    w_fall;
  logic                    w_last;

  seg_div_tick #(
    .DIV (DIV)
  ) u_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (w_div_en),
    .i_clr  (w_div_clr),
    .o_tick (w_tick)
  );

  // A tick while seg_clk is high is the falling toggle that ends a bit.
  assign w_fall = (r_state == ST_SHIFT) && w_tick && r_segclk;
  assign w_last = (r_bitcnt == BIT_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (start)            w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (w_fall && w_last) w_state_nxt = ST_LATCH;
      ST_LATCH: if (w_tick)           w_state_nxt = ST_DONE;
      ST_DONE:                        w_state_nxt = ST_IDLE;
      default:                        w_state_nxt = ST_IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    seg_latch = 1'b0;
    unique case (r_state)
      ST_SHIFT: busy = 1'b1;
      ST_LATCH: begin
        busy      = 1'b1;
        seg_latch = 1'b1;
      end
      ST_DONE:  done = 1'b1;
      default:  ;
    endcase
    w_div_en  = busy;
    w_div_clr = !busy;
  end

  // Datapath: the last falling toggle leaves the register unshifted so the
  // final bit stays on seg_sout through its whole period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift  <= '0;
      r_bitcnt <= '0;
      r_segclk <= 1'b0;
    end else if ((r_state == ST_IDLE) && start) begin
      r_shift  <= par_data;
      r_bitcnt <= '0;
      r_segclk <= 1'b0;
    end else if ((r_state == ST_SHIFT) && w_tick) begin
      r_segclk <= ~r_segclk;
      if (r_segclk && !w_last) begin
        r_shift  <= {r_shift[WIDTH-2:0], 1'b0};
        r_bitcnt <= r_bitcnt + SEG_BITCNT_W'(1);
      end
    end
  end

  assign seg_clk  = r_segclk;
  assign seg_sout = r_shift[WIDTH-1];

endmodule

// File: tb/tb_seg_shift_ctrl.sv
module tb_seg_shift_ctrl;

  logic clk;
  logic rst_n;

  // DUT A: DIV=2
  logic        a_start;
  logic [63:0] a_par;
  logic        a_busy, a_done, a_sclk, a_sout, a_latch;
  // DUT B: DIV=1
  logic        b_start;
  logic [63:0] b_par;
  logic        b_busy, b_done, b_sclk, b_sout, b_latch;

  int errors = 0;
  int checks = 0;

  logic [63:0] a_exp_q[$];
  logic [63:0] b_exp_q[$];
  logic [63:0] a_rx, b_rx;
  int a_nbits = 0, b_nbits = 0;
  int a_frames = 0, b_frames = 0;
  int a_started = 0, b_started = 0;

  seg_shift_ctrl #(.WIDTH(64), .DIV(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .par_data(a_par),
    .busy(a_busy), .done(a_done), .seg_clk(a_sclk), .seg_sout(a_sout),
    .seg_latch(a_latch)
  );

  seg_shift_ctrl #(.WIDTH(64), .DIV(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .par_data(b_par),
    .busy(b_busy), .done(b_done), .seg_clk(b_sclk), .seg_sout(b_sout),
    .seg_latch(b_latch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Receivers: model of the external chain, sampling on seg_clk rising edges.
  always @(posedge a_sclk) begin
    a_rx = {a_rx[62:0], a_sout};
    a_nbits++;
  end
  always @(posedge b_sclk) begin
    b_rx = {b_rx[62:0], b_sout};
    b_nbits++;
  end
  always @(negedge rst_n) begin
    a_nbits = 0;
    b_nbits = 0;
  end

  always @(posedge a_latch) begin
    a_frames++;
    chk("a_frame_not_requested", a_frames <= a_started, 1);
    if (a_exp_q.size() > 0) begin
      chk("a_frame_data", a_rx, a_exp_q.pop_front());
      chk("a_frame_bits", a_nbits, 64);
    end
    a_nbits = 0;
  end
  always @(posedge b_latch) begin
    b_frames++;
    chk("b_frame_not_requested", b_frames <= b_started, 1);
    if (b_exp_q.size() > 0) begin
      chk("b_frame_data", b_rx, b_exp_q.pop_front());
      chk("b_frame_bits", b_nbits, 64);
    end
    b_nbits = 0;
  end

  // Start pulse: the posedge inside this task is "edge 0"; returns in cycle 1.
  task automatic pulse_a(input logic [63:0] d);
    @(negedge clk);
    a_par = d;
    a_start = 1'b1;
    a_exp_q.push_back(d);
    a_started++;
    @(posedge clk);
    #1 a_start = 1'b0;
  endtask

  task automatic pulse_b(input logic [63:0] d);
    @(negedge clk);
    b_par = d;
    b_start = 1'b1;
    b_exp_q.push_back(d);
    b_started++;
    @(posedge clk);
    #1 b_start = 1'b0;
  endtask

  task automatic wait_done_a(input int lim);
    int n;
    n = 0;
    while (a_done !== 1'b1 && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("a_done_timeout", n < lim, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] d0;
    logic        prev_clk;
    int          rises;
    int          fr;

    rst_n   = 1'b0;
    a_start = 1'b0; a_par = '0;
    b_start = 1'b0; b_par = '0;
    a_rx = '0; b_rx = '0;
    repeat (3) @(negedge clk);
    chk("reset_a_outputs", {a_busy, a_done, a_sclk, a_sout, a_latch}, 0);
    chk("reset_b_outputs", {b_busy, b_done, b_sclk, b_sout, b_latch}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // DIV=2 single-frame timing, first start after reset.
    d0 = 64'h8000_0000_0000_0001;
    pulse_a(d0);
    rises = 0;
    prev_clk = 1'b0;
    for (int n = 1; n <= 262; n++) begin
      @(negedge clk);
      if (a_sclk === 1'b1 && prev_clk === 1'b0) rises++;
      prev_clk = a_sclk;
      chk("a_busy_cycle", a_busy, (n >= 1 && n <= 258));
      chk("a_latch_cycle", a_latch, (n == 257 || n == 258));
      chk("a_done_cycle", a_done, (n == 259));
      if (n <= 256) chk("a_sout_bit", a_sout, d0[63 - (n - 1) / 4]);
    end
    chk("a_sclk_rises", rises, 64);
    chk("a_frames_after_first", a_frames, 1);

    // Ignored starts in SHIFT and DONE, par_data changed after capture.
    d0 = 64'h0F1E_2D3C_4B5A_6978;
    pulse_a(d0);
    for (int n = 1; n <= 300; n++) begin
      @(negedge clk);
      if (n == 10) a_par = 64'hDEAD_BEEF_CAFE_F00D;
      a_start = (n == 50 || n == 259);
      if (n == 259) a_par = 64'h1111_2222_3333_4444;
      chk("a_done_ign", a_done, (n == 259));
      if (n == 300) chk("a_idle_after_ign", a_busy, 0);
    end
    a_start = 1'b0;
    chk("a_frames_after_ign", a_frames, 2);

    // Reset mid-frame at cycle 100, then a full frame after release.
    pulse_a(64'hFFFF_FFFF_FFFF_FFFF);
    for (int n = 1; n < 100; n++) @(negedge clk);
    chk("a_busy_before_abort", a_busy, 1);
    fr = a_frames;
    rst_n = 1'b0;
    #1;
    chk("a_abort_outputs", {a_busy, a_done, a_sclk, a_sout, a_latch}, 0);
    void'(a_exp_q.pop_back());
    a_started--;
    repeat (3) @(negedge clk);
    chk("a_abort_held", {a_busy, a_done, a_sclk, a_sout, a_latch}, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("a_no_latch_on_abort", a_frames, fr);
    pulse_a(64'h0123_4567_89AB_CDEF);
    wait_done_a(400);
    chk("a_frames_after_reset", a_frames, fr + 1);

    // Back-to-back: restart in the cycle after done.
    pulse_a(64'hC3C3_0000_FFFF_5A5A);
    chk("a_b2b_busy_first", a_busy, 1);
    wait_done_a(400);
    pulse_a(64'h7E81_1234_ABCD_0F0F);
    chk("a_b2b_busy_second", a_busy, 1);
    wait_done_a(400);
    chk("a_frames_b2b", a_frames, fr + 3);

    // DIV=1 frame and done timing.
    pulse_b(64'hA5A5_F00F_1234_CDEF);
    for (int n = 1; n <= 135; n++) begin
      @(negedge clk);
      chk("b_done_cycle", b_done, (n == 130));
      chk("b_latch_cycle", b_latch, (n == 129));
    end
    chk("b_frames", b_frames, 1);

    repeat (4) @(negedge clk);
    chk("a_queue_empty", a_exp_q.size(), 0);
    chk("b_queue_empty", b_exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg_shift_ctrl.md
SEG_SHIFT_CTRL -- requirements
Module: seg_shift_ctrl

Interface
REQ-001 Parameter WIDTH, default 64, number of serial bits per frame (one segment-mapped frame for the display shift-register chain).
REQ-002 Parameter DIV, default 2, serial half-period in clk cycles; legal range 1..1023; 0 is illegal.
REQ-003 clk  input  1  system clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request to transmit par_data; sampled only in IDLE.
REQ-006 par_data  input  WIDTH  segment-mapped frame; bit WIDTH-1 is sent first.
REQ-007 busy  output  1  high while a frame is being shifted or latched.
REQ-008 done  output  1  one-cycle pulse at frame completion.
REQ-009 seg_clk  output  1  serial shift clock to the external chain; data is sampled on its rising edge.
REQ-010 seg_sout  output  1  serial data bit.
REQ-011 seg_latch  output  1  frame latch/output-enable strobe to the chain.

Function
REQ-012 FSM states: IDLE, SHIFT, LATCH, DONE.
REQ-013 IDLE with start=1 at edge T: capture par_data into the shift register, set bitcnt=0 and divcnt=0, drive seg_sout=par_data[WIDTH-1] and seg_clk=0, and enter SHIFT.
REQ-014 In SHIFT, divcnt counts 0..DIV-1; at DIV-1, seg_clk toggles and divcnt returns to 0.
REQ-015 On a seg_clk high-to-low toggle: shift the register left by one and increment bitcnt; seg_sout presents the new MSB on that same edge.
REQ-016 seg_sout is stable for the full 2*DIV-cycle bit period, including across the seg_clk rising edge.
REQ-017 The falling toggle that completes bit WIDTH-1 enters LATCH instead of shifting; seg_clk stays 0.
REQ-018 SHIFT lasts exactly 2*DIV*WIDTH cycles.
REQ-019 LATCH holds seg_latch=1 for exactly DIV cycles, then enters DONE.
REQ-020 DONE lasts one cycle with done=1 and busy=0, then returns to IDLE.
REQ-021 busy=1 in SHIFT and LATCH only; busy=0 in IDLE and DONE.
REQ-022 start is ignored in SHIFT, LATCH and DONE; no queuing occurs, so a request in DONE is lost.
REQ-023 par_data changes after capture have no effect on the frame in flight.
REQ-024 DIV=1: seg_clk toggles every cycle; all rules above still hold.

Reset
REQ-025 While rst_n=0, asynchronously force: state=IDLE, busy=0, done=0, seg_clk=0, seg_sout=0, seg_latch=0, shift register=0, bitcnt=0, divcnt=0.
REQ-026 Reset mid-frame aborts the frame immediately, with no latch strobe.
REQ-027 After reset release, the first start is accepted normally.

Structure
REQ-028 Shared package seg_pkg holds the state enumeration, WIDTH default 64, and the bitcnt/divcnt width constants.
REQ-029 One sub-module, seg_div_tick: a DIV-cycle tick generator with synchronous clear, active only in SHIFT and LATCH.
REQ-030 The datapath (shift register, bitcnt) and the FSM stay in seg_shift_ctrl.

Verification
REQ-031 DIV=2, par_data=64'h8000_0000_0000_0001, start pulse at edge 0:
  - seg_sout=1 for bit 0, 0 for bits 1..62, 1 for bit 63;
  - 64 seg_clk rising edges;
  - seg_latch high in cycles 257-258;
  - done high in cycle 259 only.
REQ-032 DIV=1, par_data=64'hA5A5_F00F_1234_CDEF: a bench shift register sampling on seg_clk rising edges holds exactly this value when seg_latch rises; done arrives in cycle 130.
REQ-033 Start pulses during SHIFT (edge 50) and during DONE (edge 259), with par_data changed at edge 10: a single frame equal to the value captured at edge 0, and no second frame.
REQ-034 rst_n low at cycle 100 mid-frame: all outputs 0 within that cycle, seg_latch never asserted; a start 5 cycles after release yields a correct full frame.
REQ-035 Back-to-back frames, start re-asserted in the cycle after done: second frame starts, busy rises at the next edge, and both frames are received intact.
